br_pred_unit: RTL and testbench

//  Fetch-side branch predictor and redirect generator, the consumer end of the branch FU resolution path.

---
 rtl/br_pred_unit.sv | 172 +++++++++++++++++
 tb/tb_br_pred_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_pred_unit.sv
// Fetch-side branch predictor: direct-mapped BHT/BTB, EXE-driven training, held mispredict redirect.
// Optional build macro BP_STATS_EN adds branch/mispredict statistics counters.
//
// state    | meaning
// ---------|------------------------------------------------------------
// ST_IDLE  | accepting resolutions; train and detect mispredicts
// ST_REDIR | redirect held for fetch; resolutions are wrong-path, dropped

module br_pred_unit #(
    parameter int PC_SZ       = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             pred_req,
    input  logic [PC_SZ-1:0] pred_pc,
    output logic             pred_vld,
    output logic             pred_taken,
    output logic [PC_SZ-1:0] pred_target,
    input  logic             res_vld,
    input  logic [PC_SZ-1:0] res_pc,
    input  logic             res_is_br,
    input  logic             res_is_jmp,
    input  logic             res_taken,
    input  logic [PC_SZ-1:0] res_br_pc,
    input  logic [PC_SZ-1:0] res_no_br_pc,
    input  logic             res_pred_taken,
    input  logic [PC_SZ-1:0] res_pred_target,
    output logic             redirect_vld,
    output logic [PC_SZ-1:0] redirect_pc,
    input  logic             redirect_ack
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      stat_br_cnt,
    output logic [31:0]      stat_misp_cnt
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W = PC_SZ - IDX_W - 2;

    typedef enum logic {
        ST_IDLE,
        ST_REDIR
    } state_t;

    state_t state;

    logic [BHT_ENTRIES-1:0] tab_vld;
    logic [BHT_ENTRIES-1:0] tab_jmp;
    logic [TAG_W-1:0]       tab_tag [BHT_ENTRIES];
    logic [1:0]             tab_ctr [BHT_ENTRIES];
    logic [PC_SZ-1:0]       tab_tgt [BHT_ENTRIES];

    logic [IDX_W-1:0] p_idx;
    logic [TAG_W-1:0] p_tag;
    logic             p_hit;
    logic             p_taken;

    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic [1:0]       r_ctr;
    logic [1:0]       ctr_nxt;

    logic accept;
    logic misp;
    logic train;
    logic train_wr;

    logic [3:0] unused_pc_lsbs;
    assign unused_pc_lsbs = {pred_pc[1:0], res_pc[1:0]};

    assign p_idx   = pred_pc[IDX_W+1:2];
    assign p_tag   = pred_pc[PC_SZ-1:IDX_W+2];
    assign p_hit   = tab_vld[p_idx] && (tab_tag[p_idx] == p_tag);
    assign p_taken = p_hit && (tab_jmp[p_idx] || tab_ctr[p_idx][1]);

    assign r_idx = res_pc[IDX_W+1:2];
    assign r_tag = res_pc[PC_SZ-1:IDX_W+2];
    assign r_hit = tab_vld[r_idx] && (tab_tag[r_idx] == r_tag);
    assign r_ctr = tab_ctr[r_idx];

    assign accept   = (state == ST_IDLE) && res_vld;
    assign misp     = (res_pred_taken != res_taken) ||
                      (res_taken && (res_pred_target != res_br_pc));
    assign train    = accept && (res_is_br || res_is_jmp);
    // A not-taken miss leaves the table alone; everything else writes the entry.
    assign train_wr = train && (r_hit || res_taken);

    always_comb begin
        ctr_nxt = r_ctr;
        if (!r_hit) begin
            ctr_nxt = res_is_jmp ? 2'd3 : 2'd2;
        end else if (res_taken) begin
            if (r_ctr != 2'd3) ctr_nxt = r_ctr + 2'd1;
        end else begin
            if (r_ctr != 2'd0) ctr_nxt = r_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tab_vld <= '0;
        end else if (train_wr) begin
            tab_vld[r_idx] <= 1'b1;
        end
    end

    // Payload is only meaningful behind tab_vld, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (train_wr) begin
            tab_tag[r_idx] <= r_tag;
            tab_jmp[r_idx] <= res_is_jmp;
            tab_ctr[r_idx] <= ctr_nxt;
            if (res_taken) tab_tgt[r_idx] <= res_br_pc;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pred_vld    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_vld    <= pred_req;
            pred_taken  <= pred_req && p_taken;
            pred_target <= (pred_req && p_taken) ? tab_tgt[p_idx] : '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            redirect_vld <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && misp) begin
                        state        <= ST_REDIR;
                        redirect_vld <= 1'b1;
                        redirect_pc  <= res_taken ? res_br_pc : res_no_br_pc;
                    end
                end
                ST_REDIR: begin
                    if (redirect_ack) begin
                        state        <= ST_IDLE;
                        redirect_vld <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    redirect_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            stat_br_cnt   <= '0;
            stat_misp_cnt <= '0;
        end else begin
            if (train)           stat_br_cnt   <= stat_br_cnt + 32'd1;
            if (accept && misp)  stat_misp_cnt <= stat_misp_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_br_pred_unit.sv
// Bench for br_pred_unit: directed scenarios plus random traffic against a behavioural table model.
// Build with BP_STATS_EN defined to also check the statistics counters.

module tb_br_pred_unit;

    localparam int N = 64;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_vld;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_vld;
    logic [31:0] res_pc;
    logic        res_is_br;
    logic        res_is_jmp;
    logic        res_taken;
    logic [31:0] res_br_pc;
    logic [31:0] res_no_br_pc;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
`ifdef BP_STATS_EN
    logic [31:0] stat_br_cnt;
    logic [31:0] stat_misp_cnt;
`endif

    always #5 clk_in = ~clk_in;

    br_pred_unit #(.PC_SZ(32), .BHT_ENTRIES(N)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .pred_req        (pred_req),
        .pred_pc         (pred_pc),
        .pred_vld        (pred_vld),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_vld         (res_vld),
        .res_pc          (res_pc),
        .res_is_br       (res_is_br),
        .res_is_jmp      (res_is_jmp),
        .res_taken       (res_taken),
        .res_br_pc       (res_br_pc),
        .res_no_br_pc    (res_no_br_pc),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .redirect_vld    (redirect_vld),
        .redirect_pc     (redirect_pc),
        .redirect_ack    (redirect_ack)
`ifdef BP_STATS_EN
        ,
        .stat_br_cnt     (stat_br_cnt),
        .stat_misp_cnt   (stat_misp_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: one record per table slot, counter as a plain integer 0..3.
    typedef struct {
        bit          v;
        int unsigned tag;
        bit          jmp;
        int          ctr;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mt [N];
    bit          m_redir;
    logic [31:0] m_rpc;
    bit          m_pv;
    bit          m_pt;
    logic [31:0] m_ptg;
    int unsigned m_brc;
    int unsigned m_mispc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit mdl_taken(input logic [31:0] pc);
        ent_t e;
        e = mt[idx_of(pc)];
        return e.v && (e.tag == tag_of(pc)) && (e.jmp || e.ctr >= 2);
    endfunction

    function automatic logic [31:0] mdl_target(input logic [31:0] pc);
        return mdl_taken(pc) ? mt[idx_of(pc)].tgt : 32'h0;
    endfunction

    task automatic mdl_reset();
        foreach (mt[i]) mt[i].v = 1'b0;
        m_redir = 1'b0;
        m_rpc   = '0;
        m_pv    = 1'b0;
        m_pt    = 1'b0;
        m_ptg   = '0;
        m_brc   = 0;
        m_mispc = 0;
    endtask

    task automatic check_outputs();
        chk("pred_vld",     pred_vld,     m_pv);
        chk("pred_taken",   pred_taken,   m_pt);
        chk("pred_target",  pred_target,  m_ptg);
        chk("redirect_vld", redirect_vld, m_redir);
        chk("redirect_pc",  redirect_pc,  m_rpc);
`ifdef BP_STATS_EN
        chk("stat_br_cnt",   stat_br_cnt,   m_brc);
        chk("stat_misp_cnt", stat_misp_cnt, m_mispc);
`endif
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs are compared.
    task automatic tick();
        bit          nt;
        logic [31:0] ntg;
        bit          misp;
        bit          hit;
        int          i;
        @(posedge clk_in);
        nt  = pred_req && mdl_taken(pred_pc);
        ntg = nt ? mdl_target(pred_pc) : 32'h0;
        if (!m_redir) begin
            if (res_vld) begin
                misp = (res_pred_taken != res_taken) ||
                       (res_taken && (res_pred_target != res_br_pc));
                if (misp) begin
                    m_redir = 1'b1;
                    m_rpc   = res_taken ? res_br_pc : res_no_br_pc;
                    m_mispc++;
                end
                if (res_is_br || res_is_jmp) begin
                    m_brc++;
                    i   = idx_of(res_pc);
                    hit = mt[i].v && (mt[i].tag == tag_of(res_pc));
                    if (hit) begin
                        if (res_taken) begin
                            mt[i].ctr = (mt[i].ctr < 3) ? mt[i].ctr + 1 : 3;
                            mt[i].tgt = res_br_pc;
                        end else begin
                            mt[i].ctr = (mt[i].ctr > 0) ? mt[i].ctr - 1 : 0;
                        end
                        mt[i].jmp = res_is_jmp;
                    end else if (res_taken) begin
                        mt[i].v   = 1'b1;
                        mt[i].tag = tag_of(res_pc);
                        mt[i].jmp = res_is_jmp;
                        mt[i].ctr = res_is_jmp ? 3 : 2;
                        mt[i].tgt = res_br_pc;
                    end
                end
            end
        end else if (redirect_ack) begin
            m_redir = 1'b0;
        end
        m_pv  = pred_req;
        m_pt  = nt;
        m_ptg = ntg;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        #1;
        mdl_reset();
        check_outputs();
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
    endtask

    task automatic res_go(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        res_vld         = 1'b1;
        res_pc          = pc;
        res_is_br       = br;
        res_is_jmp      = jmp;
        res_taken       = tk;
        res_br_pc       = tgt;
        res_no_br_pc    = pc + 32'd4;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
        tick();
        res_vld    = 1'b0;
        res_is_br  = 1'b0;
        res_is_jmp = 1'b0;
    endtask

    task automatic pred_go(input logic [31:0] pc);
        pred_req = 1'b1;
        pred_pc  = pc;
        tick();
        pred_req = 1'b0;
    endtask

    task automatic ack_go();
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h1000 + $urandom_range(0, 2) * (4 * N) + $urandom_range(0, 7) * 4;
    endfunction

    initial begin
        reset_in        = 1'b1;
        pred_req        = 1'b0;
        pred_pc         = '0;
        res_vld         = 1'b0;
        res_pc          = '0;
        res_is_br       = 1'b0;
        res_is_jmp      = 1'b0;
        res_taken       = 1'b0;
        res_br_pc       = '0;
        res_no_br_pc    = '0;
        res_pred_taken  = 1'b0;
        res_pred_target = '0;
        redirect_ack    = 1'b0;
        do_reset();

        // Cold lookup
        pred_go(32'h100);
        chk("t1_vld", pred_vld, 1);
        chk("t1_taken", pred_taken, 0);
        chk("t1_target", pred_target, 0);

        // Taken branch allocates with weakly-taken counter
        res_go(32'h100, 1, 0, 1, 32'h80, 0, 0);
        chk("t2_rvld", redirect_vld, 1);
        chk("t2_rpc", redirect_pc, 32'h80);
        ack_go();
        chk("t2_drop", redirect_vld, 0);
        pred_go(32'h100);
        chk("t2_taken", pred_taken, 1);
        chk("t2_target", pred_target, 32'h80);

        // Not-taken twice, then taken once: counter must not wrap below zero
        res_go(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        chk("t3_rvld", redirect_vld, 1);
        chk("t3_rpc", redirect_pc, 32'h104);
        ack_go();
        pred_go(32'h100);
        chk("t3_taken_c1", pred_taken, 0);
        res_go(32'h100, 1, 0, 0, 32'h80, 0, 0);
        chk("t3_no_redir", redirect_vld, 0);
        res_go(32'h100, 1, 0, 1, 32'h80, 0, 0);
        ack_go();
        pred_go(32'h100);
        chk("t3_floor", pred_taken, 0);

        // Held redirect ignores wrong-path resolutions
        res_go(32'h100, 1, 0, 1, 32'h80, 0, 0);
        for (int k = 0; k < 5; k++) begin
            res_go(32'h300, 1, 0, 1, 32'h700, 0, 0);
            chk("t4_hold_vld", redirect_vld, 1);
            chk("t4_hold_pc", redirect_pc, 32'h80);
        end
        ack_go();
        chk("t4_drop", redirect_vld, 0);
        pred_go(32'h300);
        chk("t4_no_train", pred_taken, 0);

        // JAL entry, aliasing tag miss, JALR redirect without table write
        res_go(32'h200, 0, 1, 1, 32'h400, 0, 0);
        chk("t5_rpc_jal", redirect_pc, 32'h400);
        ack_go();
        pred_go(32'h200);
        chk("t5_jal_taken", pred_taken, 1);
        chk("t5_jal_tgt", pred_target, 32'h400);
        pred_go(32'h200 + 4 * N);
        chk("t5_alias", pred_taken, 0);
        res_go(32'h200 + 4 * N, 0, 0, 1, 32'h500, 0, 0);
        chk("t5_jalr_vld", redirect_vld, 1);
        chk("t5_jalr_pc", redirect_pc, 32'h500);
        ack_go();
        pred_go(32'h200);
        chk("t5_keep_tgt", pred_target, 32'h400);

        // Reset in the middle of a redirect invalidates the table
        res_go(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        do_reset();
        chk("rst_redir", redirect_vld, 0);
        pred_go(32'h200);
        chk("rst_table", pred_taken, 0);

`ifdef BP_STATS_EN
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 5 || k == 8) begin
                res_go(32'h800 + 4 * k, 1, 0, 1, 32'h900, 0, 0);
                ack_go();
            end else begin
                res_go(32'h800 + 4 * k, 1, 0, 0, 32'h900, 0, 0);
            end
        end
        chk("t6_br", stat_br_cnt, 10);
        chk("t6_misp", stat_misp_cnt, 3);
        reset_in = 1'b1;
        #1;
        chk("t6_br_rst", stat_br_cnt, 0);
        chk("t6_misp_rst", stat_misp_cnt, 0);
        do_reset();
`endif

        // Random traffic over a small PC pool to force hits, aliasing and saturation
        for (int c = 0; c < 3000; c++) begin
            int          r;
            logic [31:0] pc;
            if ($urandom_range(0, 499) == 0) do_reset();
            pred_req = ($urandom_range(0, 9) < 6);
            pred_pc  = pool_pc();
            res_vld  = ($urandom_range(0, 9) < 6);
            pc       = pool_pc();
            r        = $urandom_range(0, 9);
            res_pc       = pc;
            res_is_br    = (r < 6);
            res_is_jmp   = (r >= 6 && r < 8);
            res_taken    = (r < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
            res_br_pc    = pool_pc();
            res_no_br_pc = pc + 32'd4;
            if ($urandom_range(0, 9) < 8) begin
                res_pred_taken  = mdl_taken(pc);
                res_pred_target = mdl_target(pc);
                if (mdl_taken(pc) && $urandom_range(0, 9) < 8) res_br_pc = mdl_target(pc);
            end else begin
                res_pred_taken  = 1'($urandom_range(0, 1));
                res_pred_target = pool_pc();
            end
            redirect_ack = ($urandom_range(0, 9) < 4);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
